bin2bcd_converter: RTL and testbench
====================================

Name: bin2bcd_converter

Overview:
- Sequential double-dabble (shift-add-3) converter that turns an unsigned binary value into eight BCD digits.
- Drives the BCD3..BCD0 and BCD7..BCD4 inputs of the seven-segment driver directly.
- Converts on request, holds the result stable between conversions, and signals completion with a one-cycle pulse.

Parameters:
- WIDTH, 27, bit width of the binary input; legal range 1..27. The digit count is fixed at 8, so the representable maximum is 99,999,999.

Ports:
- Clk  input  1  system clock (100 MHz)
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request a conversion of Bin; sampled only when Busy=0
- Bin  input  WIDTH  unsigned binary value, captured on the accepted Start edge
- Busy  output  1  high while a conversion is in progress
- Done  output  1  one-cycle pulse when BCD outputs update
- Overflow  output  1  captured value exceeded 99,999,999; held until the next update
- BCD7..BCD0  output  4 each  result digits; BCD7 most significant, BCD0 least significant

Behaviour:
- Reset is synchronous and active-high on Clk. Reset values:
  - Busy=0, Done=0, Overflow=0
  - all BCD digits 4'h0
  - state IDLE, internal shift registers cleared
- States are IDLE, SHIFT and DONE.
- IDLE:
  - Start=1 at edge k: load Bin into the binary shift register, clear the 32-bit BCD accumulator, load the iteration counter with WIDTH, set the overflow flag to (Bin > 99,999,999), and go to SHIFT.
  - Busy=1 from edge k onward.
- SHIFT, once per cycle:
  - Each 4-bit accumulator nibble >= 5 gets +3 (per nibble, no carry between nibbles).
  - Then {accumulator, binary} shifts left by 1 and the counter decrements.
  - The edge where the counter goes 1->0 moves to DONE. Exactly WIDTH SHIFT cycles occur.
- DONE, one cycle; at the edge leaving DONE (edge k+WIDTH+1):
  - BCD outputs <= accumulator digits, or all 4'h9 if the overflow flag is set.
  - Overflow <= overflow flag.
  - Done=1 for exactly that cycle, Busy=0, return to IDLE.
- Latency: fixed at WIDTH+1 cycles from the accepted Start edge to the output update. It is the same for every value, including overflow values.
- Output stability: BCD and Overflow change only at the DONE update edge or on Reset. They never show intermediate accumulator values.
- Start while Busy=1 is ignored: no queueing, no restart, and Bin changes are also ignored.
- Start is accepted in the cycle where Done=1, since Busy=0 and state is IDLE. This allows back-to-back conversions every WIDTH+2 cycles.
- Start held high continuously: a new conversion begins each time IDLE is reached.
- Reset mid-conversion aborts immediately: all outputs take their reset values on the next edge and Done does not pulse. Reset takes priority over Start.
- Bin narrower than 27 bits (WIDTH < 27) is zero-extended for the overflow compare. Overflow is impossible when WIDTH <= 26.

Optional Feature:
- Macro: BIN2BCD_LEADING_ZERO_BLANK_EN
- Defined:
  - At the DONE update, each leading zero digit from BCD7 down to BCD1 is replaced with 4'hF (blank code), stopping at the first nonzero digit.
  - BCD0 is never blanked, so value 0 shows as BCD7..BCD1=F, BCD0=0.
  - No blanking is applied to the all-9 overflow pattern.
  - Blanking is registered and adds no latency.
- Undefined: leading zeros are output as 4'h0. The Start-to-update timing is identical in both builds.

Test Plan:
- Reset, then Bin=0 with Start pulse -> Done at 28 cycles after the Start edge; BCD7..BCD0=0,0,0,0,0,0,0,0 (blank build: F,F,F,F,F,F,F,0); Overflow=0.
- Bin=12,345,678, Start -> BCD7..BCD0=1,2,3,4,5,6,7,8; Busy high for 28 cycles; Done high for exactly 1 cycle.
- Bin=99,999,999 then Bin=100,000,000 back-to-back, with Start asserted in the Done cycle -> first result all 9s with Overflow=0; second result all 9s with Overflow=1, arriving 29 cycles after the first.
- Bin=305, Start; 5 cycles later Bin=999 and Start=1 again -> the second Start is ignored; result 0,0,0,0,0,3,0,5 (blank build: F,F,F,F,F,3,0,5).
- Bin=4,096 and Start, then Reset asserted 10 cycles later -> no Done pulse; all outputs 0 and Busy=0 on the next edge; a subsequent Start with Bin=42 yields 0,0,0,0,0,0,4,2.
- Randomised sweep of 1,000 values in [0, 2^27-1] checked against a reference decimal split -> digits match for values <= 99,999,999; all 9s with Overflow=1 for larger values.

Source files
------------

// File: rtl/bin2bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter producing eight digits for the seven-segment driver.
// Optional build macro BIN2BCD_LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code 4'hF.
module bin2bcd_converter #(
   parameter int unsigned WIDTH = 27
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Bin,
   output logic             Busy,
   output logic             Done,
   output logic             Overflow,
   output logic [3:0]       BCD7,
   output logic [3:0]       BCD6,
   output logic [3:0]       BCD5,
   output logic [3:0]       BCD4,
   output logic [3:0]       BCD3,
   output logic [3:0]       BCD2,
   output logic [3:0]       BCD1,
   output logic [3:0]       BCD0
);

   localparam int unsigned DIGITS = 8;
   localparam int unsigned ACC_W  = 4 * DIGITS;
   localparam int unsigned CW     = $clog2(WIDTH + 1);
   localparam logic [31:0] MAX_DEC   = 32'd99_999_999;
   localparam logic [ACC_W-1:0] ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] bin_sr;
   logic [ACC_W-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             ovf_flag;
   logic [ACC_W-1:0] result;
   logic [ACC_W-1:0] adj_c;
   logic [ACC_W-1:0] result_c;

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
   // Blank leading zeros from the top digit down; the units digit always shows.
   function automatic logic [ACC_W-1:0] blank_leading(input logic [ACC_W-1:0] d);
      logic lead;
      blank_leading = d;
      lead = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         if (lead && d[4*i +: 4] == 4'h0) blank_leading[4*i +: 4] = 4'hF;
         else lead = 1'b0;
      end
   endfunction
`else
   function automatic logic [ACC_W-1:0] blank_leading(input logic [ACC_W-1:0] d);
      blank_leading = d;
   endfunction
`endif

   // Add-3 correction on every nibble that would overflow decimal after the shift.
   always_comb begin
      adj_c = acc;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (acc[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   // Value presented at the update edge; the overflow pattern is never blanked.
   always_comb begin
      result_c = ovf_flag ? ALL_NINES : blank_leading(acc);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= ST_IDLE;
         bin_sr   <= '0;
         acc      <= '0;
         cnt      <= '0;
         ovf_flag <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Overflow <= 1'b0;
         result   <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  bin_sr   <= Bin;
                  acc      <= '0;
                  cnt      <= CW'(WIDTH);
                  ovf_flag <= (32'(Bin) > MAX_DEC);
                  Busy     <= 1'b1;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               acc    <= ACC_W'({adj_c, bin_sr[WIDTH-1]});
               bin_sr <= bin_sr << 1;
               cnt    <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= ST_DONE;
            end
            ST_DONE: begin
               result   <= result_c;
               Overflow <= ovf_flag;
               Done     <= 1'b1;
               Busy     <= 1'b0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign BCD7 = result[31:28];
   assign BCD6 = result[27:24];
   assign BCD5 = result[23:20];
   assign BCD4 = result[19:16];
   assign BCD3 = result[15:12];
   assign BCD2 = result[11:8];
   assign BCD1 = result[7:4];
   assign BCD0 = result[3:0];

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Scoreboard bench for bin2bcd_converter: expected digits, overflow and update cycle are queued at each
// accepted Start and compared when Done pulses; outputs are also checked for stability every cycle.
module tb_bin2bcd_converter;

   localparam int unsigned W = 27;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         Start;
   logic [W-1:0] Bin;
   logic         Busy;
   logic         Done;
   logic         Overflow;
   logic [3:0]   BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0;
   logic [31:0]  bcd;

   typedef struct {
      logic [31:0] bcd;
      logic        ovf;
      int unsigned cyc;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [31:0] shown = '0;
   logic        shown_ovf = 1'b0;

   bin2bcd_converter #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Bin(Bin),
      .Busy(Busy), .Done(Done), .Overflow(Overflow),
      .BCD7(BCD7), .BCD6(BCD6), .BCD5(BCD5), .BCD4(BCD4),
      .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0)
   );

   assign bcd = {BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: plain decimal split of the value, then optional blanking.
   function automatic logic [32:0] model(input int unsigned v);
      logic [31:0] d;
      int unsigned t;
      logic        lead;
      if (v > 32'd99_999_999) return {1'b1, 32'h9999_9999};
      t = v;
      for (int i = 0; i < 8; i++) begin
         d[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
      lead = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         if (lead && d[4*i +: 4] == 4'h0) d[4*i +: 4] = 4'hF;
         else lead = 1'b0;
      end
`else
      lead = 1'b0;
`endif
      return {lead & 1'b0, d};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Called right after an edge with Start driven high for the next edge.
   task automatic push(input int unsigned v);
      exp_t        e;
      logic [32:0] m;
      m     = model(v);
      e.bcd = m[31:0];
      e.ovf = m[32];
      e.cyc = cyc + W + 2;
      q.push_back(e);
   endtask

   task automatic start_pulse(input int unsigned v);
      Bin   = W'(v);
      Start = 1'b1;
      push(v);
      tick();
      Start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && q.size() != 0; i++) tick();
      check_val("drain", 64'(q.size()), 64'd0);
      q.delete();
      tick();
   endtask

   // Monitor: compare on Done, flag missing/spurious pulses, and require outputs to hold otherwise.
   always @(negedge Clk) begin
      exp_t e;
      if (Done) begin
         if (q.size() == 0) begin
            check_val("spurious_done", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            check_val("bcd", 64'(bcd), 64'(e.bcd));
            check_val("ovf", 64'(Overflow), 64'(e.ovf));
            check_val("latency", 64'(cyc), 64'(e.cyc));
            shown     = e.bcd;
            shown_ovf = e.ovf;
         end
      end else if (q.size() != 0 && cyc >= q[0].cyc) begin
         check_val("done_missing", 64'd0, 64'd1);
         void'(q.pop_front());
      end
      check_val("stable", {31'd0, Overflow, bcd}, {31'd0, shown_ovf, shown});
      if (Reset) begin
         shown     = '0;
         shown_ovf = 1'b0;
         q.delete();
      end
   end

   initial begin
      int unsigned n;
      int unsigned v;
      Reset = 1'b1;
      Start = 1'b0;
      Bin   = '0;
      repeat (3) tick();
      @(negedge Clk);
      check_val("rst_busy", 64'(Busy), 64'd0);
      check_val("rst_done", 64'(Done), 64'd0);
      check_val("rst_ovf", 64'(Overflow), 64'd0);
      check_val("rst_bcd", 64'(bcd), 64'd0);
      tick();
      Reset = 1'b0;
      tick();

      // Zero value
      start_pulse(0);
      wait_done();

      // Busy window and single-cycle Done
      n = cyc;
      Bin   = W'(12_345_678);
      Start = 1'b1;
      push(12_345_678);
      tick();
      Start = 1'b0;
      for (int i = 0; i <= int'(W); i++) begin
         @(negedge Clk);
         check_val("busy_high", 64'(Busy), 64'd1);
      end
      @(negedge Clk);
      check_val("busy_low", 64'(Busy), 64'd0);
      check_val("done_pulse", 64'(Done), 64'd1);
      @(negedge Clk);
      check_val("done_once", 64'(Done), 64'd0);
      tick();
      check_val("b2b_gap", 64'(cyc - n), 64'(W + 4));
      tick();

      // Back-to-back with Start in the Done cycle
      n = cyc;
      Bin   = W'(99_999_999);
      Start = 1'b1;
      push(99_999_999);
      tick();
      Start = 1'b0;
      while (cyc < n + W + 2) tick();
      Bin   = W'(100_000_000);
      Start = 1'b1;
      push(100_000_000);
      tick();
      Start = 1'b0;
      wait_done();

      // Start while busy is ignored
      start_pulse(305);
      repeat (4) tick();
      Bin   = W'(999);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_done();

      // Reset mid-conversion aborts without Done
      start_pulse(4096);
      repeat (9) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      @(negedge Clk);
      check_val("abort_busy", 64'(Busy), 64'd0);
      check_val("abort_done", 64'(Done), 64'd0);
      check_val("abort_bcd", 64'(bcd), 64'd0);
      check_val("abort_ovf", 64'(Overflow), 64'd0);
      repeat (40) tick();
      start_pulse(42);
      wait_done();

      // Random sweep with Start held high throughout
      Start = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         v   = $urandom_range(32'd134_217_727, 32'd0);
         Bin = W'(v);
         push(v);
         repeat (W + 1) tick();
         if (i == 999) Start = 1'b0;
         tick();
      end
      Start = 1'b0;
      wait_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Bench-level watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
